mdu_issue_ctrl: RTL
===================

Name: mdu_issue_ctrl

Overview:
- Issue controller for the E-stage multiply/divide unit.
- Takes the decoded MD-class instruction in E and generates the unit's start strobe and operation code.
- Tracks the multi-cycle mult/div occupancy with its own latency counter and produces the D-stage stall for any MD-class instruction (mult/div/mfhi/mflo/mthi/mtlo) while the unit is occupied.
- Sits between the hazard unit and the MDU. It blocks illegal issue and flags it.

Parameters:
- MULT_LAT, 5, cycles from mult/multu start until HI/LO hold the result (busy cycles).
- DIV_LAT, 10, cycles from div/divu start until HI/LO hold the result.
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_LAT, DIV_LAT).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- D_md_use  in  1  instruction in D is MD-class.
- E_md_valid  in  1  instruction in E is MD-class and not a bubble.
- E_md_op  in  4  op code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO; 8-15 unused.
- mdu_start  out  1  start strobe to the MDU (combinational).
- mdu_op  out  4  op code to the MDU; 4'hF means NOP (combinational).
- mdu_busy  out  1  unit occupied by mult/div (registered).
- mdu_done  out  1  one-cycle pulse on the last busy cycle (registered).
- stall_D  out  1  freeze D/F, bubble into E (combinational).
- issue_err  out  1  sticky: illegal issue was attempted (registered).

Behaviour:
- Reset (reset==0 at posedge):
  - State IDLE, cnt=0, mdu_busy=0, mdu_done=0, issue_err=0.
  - Reset mid-operation abandons the count immediately. No done pulse follows.
- States: IDLE, RUN.
- accept = E_md_valid & (state==IDLE) & (E_md_op<=7).
- mdu_op = accept ? E_md_op : 4'hF.
- mdu_start = accept & (E_md_op<=3).
- IDLE:
  - mult/multu accepted: next RUN, cnt<=MULT_LAT, mdu_busy<=1.
  - div/divu accepted: next RUN, cnt<=DIV_LAT, mdu_busy<=1.
  - MFHI/MFLO/MTHI/MTLO: pass through with no state change. They complete in the issue cycle.
- RUN:
  - cnt>1: cnt<=cnt-1; mdu_done<=1 when cnt==2.
  - cnt==1: state<=IDLE, cnt<=0, mdu_busy<=0, mdu_done<=0.
- Timing consequences:
  - mdu_busy is high for exactly LAT consecutive cycles, starting the cycle after mdu_start.
  - mdu_done is high in the final busy cycle only.
  - In the first cycle back in IDLE, HI/LO are valid and a new op may issue.
- stall_D = D_md_use & (mdu_busy | mdu_start).
  - Covers the back-to-back case where D holds an MD instruction while E starts a mult/div.
- Illegal issue:
  - Condition: E_md_valid while in RUN, or E_md_op>=8 in any state.
  - Response: mdu_op=4'hF, mdu_start=0, issue_err<=1 (held until reset). State and cnt are unaffected.
- Simultaneous events:
  - The D_md_use check uses the current-cycle mdu_busy.
  - A non-MD D instruction never stalls, even while RUN.
- The controller does not inspect operands. Divide-by-zero timing is identical to normal division.

Test Plan:
- Reset held low 2 cycles with E_md_valid=1, op=0 -> all outputs 0, mdu_op=F. Release, mult issued -> mdu_start=1, mdu_op=0 that cycle; mdu_busy high cycles 1..5; mdu_done only at cycle 5; busy=0 at cycle 6.
- div issued with D_md_use=1 every cycle -> stall_D=1 for 11 cycles (issue cycle + 10 busy); stall_D=0 at cycle 11.
- mfhi issued while IDLE -> mdu_op=4, mdu_start=0, mdu_busy stays 0, stall_D=0 even with D_md_use=1.
- multu issued, then E_md_valid=1, op=6 at busy cycle 2 -> mdu_op=F, issue_err=1 from the next cycle; busy still ends after cycle 5.
- divu issued, reset asserted at busy cycle 4 -> next cycle busy=0, done=0, IDLE. An immediate mult then issues normally with 5 busy cycles.
- E_md_op=9 with E_md_valid=1 in IDLE -> mdu_op=F, no start, issue_err=1. A non-MD D instruction (D_md_use=0) during RUN -> stall_D=0.

Source files
------------

// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl
//   Issue controller for the E-stage multiply/divide unit. Accepts the decoded
//   MD-class instruction in E, produces the MDU start strobe and op code, tracks
//   mult/div occupancy with a latency counter, stalls D-stage MD instructions
//   while the unit is occupied, and flags illegal issue attempts (sticky).
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous active-low reset
//   D_md_use    in   instruction in D is MD-class
//   E_md_valid  in   instruction in E is MD-class and not a bubble
//   E_md_op     in   [3:0] 0 MULT,1 MULTU,2 DIV,3 DIVU,4 MFHI,5 MFLO,6 MTHI,7 MTLO
//   mdu_start   out  start strobe to the MDU (combinational)
//   mdu_op      out  [3:0] op code to the MDU, 4'hF = NOP (combinational)
//   mdu_busy    out  unit occupied by mult/div (registered)
//   mdu_done    out  pulse on the last busy cycle (registered)
//   stall_D     out  freeze D/F, bubble into E (combinational)
//   issue_err   out  sticky illegal-issue flag (registered)
module mdu_issue_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       D_md_use,
  input  logic       E_md_valid,
  input  logic [3:0] E_md_op,
  output logic       mdu_start,
  output logic [3:0] mdu_op,
  output logic       mdu_busy,
  output logic       mdu_done,
  output logic       stall_D,
  output logic       issue_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic w_op_legal;
  logic w_accept;
  logic w_start;
  logic w_illegal;

  // Nothing issues while the block is held in reset, so the MDU never sees a
  // start strobe during the reset window.
  assign w_op_legal = (E_md_op <= 4'd7);
  assign w_accept   = reset & E_md_valid & (r_state == ST_IDLE) & w_op_legal;
  assign w_start    = w_accept & (E_md_op <= 4'd3);
  assign w_illegal  = reset & E_md_valid & ((r_state == ST_RUN) | ~w_op_legal);

  assign mdu_start = w_start;
  assign mdu_op    = w_accept ? E_md_op : 4'hF;
  assign mdu_busy  = r_busy;
  assign mdu_done  = r_done;
  assign issue_err = r_err;
  // Including the start strobe catches an MD instruction in D sitting right
  // behind a mult/div that is issuing this cycle (busy not yet registered).
  assign stall_D   = D_md_use & (r_busy | w_start);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_illegal) begin
        r_err <= 1'b1;
      end
      if (r_state == ST_IDLE) begin
        if (w_start) begin
          r_state <= ST_RUN;
          // op bit 1 separates div/divu (2,3) from mult/multu (0,1)
          r_cnt   <= E_md_op[1] ? DIV_CNT : MULT_CNT;
          r_busy  <= 1'b1;
        end
      end else begin
        if (r_cnt > CNT_ONE) begin
          r_cnt  <= r_cnt - CNT_ONE;
          // cnt==2 now means cnt==1 next cycle: the final busy cycle
          r_done <= (r_cnt == CNT_TWO);
        end else begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      end
    end
  end

endmodule
